// File: rtl/riscv_fetch_unit.sv
`timescale 1ns/1ps
// riscv_fetch_unit: instruction fetch stage.
// Owns the fetch PC and issues word requests to instruction memory. It accepts
// in-order responses, buffers {pc, instr} pairs in a small FIFO and presents
// them to decode. A redirect from execute flushes the buffer and discards
// responses that are still in flight.
// Ports:
//   clk, rst          core clock, synchronous active-high reset
//   imem_req_*        request channel (valid/ready), word-aligned address
//   imem_rsp_*        in-order response channel, no backpressure
//   redirect_*        single-cycle PC redirect from execute
//   if_*              instruction/PC to decode (valid/ready)
module riscv_fetch_unit #(
    parameter int unsigned    XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(0),
    parameter int unsigned    FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 2;
    localparam int unsigned KW    = CNT_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [XLEN-1:0]  PC_STEP = XLEN'(4);

    logic [XLEN-1:0]  fetch_pc;
    logic [XLEN-1:0]  rsp_pc;
    logic [XLEN-1:0]  buf_pc    [FIFO_DEPTH];
    logic [XLEN-1:0]  buf_instr [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] kill_cnt;

    logic             req_fire;
    logic             rsp_live;
    logic             rsp_kill;
    logic             push;
    logic             pop;
    logic [XLEN-1:0]  redirect_tgt;
    logic [KW-1:0]    kill_sum;
    logic             unused_redirect_lsbs;

    assign redirect_tgt         = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Credit: live in-flight requests plus buffered entries never exceed the FIFO.
    assign imem_req_valid = !rst && !redirect_valid && ((outstanding + fifo_count) < DEPTH_C);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses belonging to requests issued before a redirect are dropped first.
    assign rsp_kill = imem_rsp_valid && (kill_cnt != '0);
    assign rsp_live = imem_rsp_valid && (kill_cnt == '0);
    assign push     = rsp_live && !redirect_valid && !rst;

    assign if_valid = !rst && (fifo_count != '0);
    assign if_instr = if_valid ? buf_instr[rd_ptr] : '0;
    assign if_pc    = if_valid ? buf_pc[rd_ptr]    : '0;
    assign pop      = if_valid && if_ready;

    // On redirect every live request becomes a kill; a response landing the
    // same cycle is one of them and is consumed right away.
    assign kill_sum = {1'b0, kill_cnt} + {1'b0, outstanding} - KW'(imem_rsp_valid);

    // Control state: PCs, FIFO pointers and request accounting.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fifo_count  <= '0;
            outstanding <= '0;
            kill_cnt    <= '0;
        end else if (redirect_valid) begin
            fetch_pc    <= redirect_tgt;
            rsp_pc      <= redirect_tgt;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fifo_count  <= '0;
            outstanding <= '0;
            kill_cnt    <= kill_sum[CNT_W-1:0];
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + PC_STEP;
            end
            if (push) begin
                rsp_pc <= rsp_pc + PC_STEP;
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (rsp_kill) begin
                kill_cnt <= kill_cnt - CNT_W'(1);
            end
            fifo_count  <= fifo_count + CNT_W'(push) - CNT_W'(pop);
            outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(rsp_live);
        end
    end

    // FIFO storage; contents need no reset because fifo_count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc[wr_ptr]    <= rsp_pc;
            buf_instr[wr_ptr] <= imem_rsp_data;
        end
    end

    // Buffer never overflows: a push into a full FIFO needs a same-cycle pop.
    a_fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (fifo_count == DEPTH_C)));

    // Kill accumulation must fit the counter and never go negative.
    a_kill_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(redirect_valid && kill_sum[CNT_W]));

    // Every response must match a live or killed request.
    a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
        !(imem_rsp_valid && (kill_cnt == '0) && (outstanding == '0)));

    a_outstanding_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(req_fire && !rsp_live && (outstanding == '1)));

endmodule

// File: tb/tb_riscv_fetch_unit.sv
`timescale 1ns/1ps
// Testbench for riscv_fetch_unit: in-order memory model with programmable
// latency, expected-PC scoreboard filled by the stimulus and drained by a
// monitor whenever decode accepts an instruction.
module tb_riscv_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    riscv_fetch_unit #(
        .XLEN       (32),
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          mem_lat  = 1;
    int          fires    = 0;
    int          seg_pops = 0;
    mreq_t       pend[$];
    logic [31:0] exp_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A3C_0F96;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, want);
    endtask

    // Expected instruction stream from a start PC, replacing any older stream.
    task automatic set_segment(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(start + 32'(4 * i));
        seg_pops = 0;
    endtask

    // Stimulus runs 1ns after the falling edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_pops(input int n, input string name);
        int t;
        t = 0;
        while (seg_pops < n && t < 200) begin
            tick();
            t++;
        end
        chk(name, 32'((seg_pops >= n) ? n : seg_pops), 32'(n));
    endtask

    task automatic do_reset(input int lat, input logic ir);
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        if_ready       = ir;
        mem_lat        = lat;
        set_segment(RESET_PC);
        tick();
        tick();
    endtask

    // In-order memory: response driven at +0, accepted request captured at +3.
    initial begin : memory_model
        mreq_t r;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                pend.delete();
                fires          = 0;
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = '0;
            end else if (pend.size() > 0 && pend[0].due == cyc) begin
                r              = pend.pop_front();
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(r.addr);
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = 32'hDEAD_BEEF;
            end
            #3;
            if (imem_req_valid && imem_req_ready) begin
                pend.push_back('{addr: imem_req_addr, due: cyc + mem_lat});
                fires++;
            end
        end
    end

    // Monitor: every accepted instruction is compared with the scoreboard head.
    initial begin : monitor
        logic [31:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && !redirect_valid && if_valid && if_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_underflow: got if_pc 0x%08h expected no instruction", if_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_pc", if_pc, e);
                    chk("sb_instr", if_instr, mem_word(e));
                    seg_pops++;
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int k;
        int t;

        // Reset state.
        do_reset(1, 1'b1);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr", imem_req_addr, RESET_PC);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_instr", if_instr, 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);

        // Streaming from reset: request, response, then registered FIFO output.
        rst = 1'b0;
        k = 0;
        while (!if_valid && k < 10) begin
            tick();
            k++;
        end
        chk("first_valid_latency", 32'(k), 32'd2);
        chk("first_if_pc", if_pc, 32'h0);
        wait_pops(8, "stream_pops");

        // Decode stalled: two requests fill the credit, head held stable.
        do_reset(1, 1'b0);
        rst = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i >= 3) chk("stall_if_pc", if_pc, 32'h0);
        end
        chk("stall_req_count", 32'(fires), 32'd2);
        chk("stall_if_valid", 32'(if_valid), 32'd1);

        // Memory stalled: request for 0x8 held until accepted.
        if_ready       = 1'b1;
        imem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_req_valid", 32'(imem_req_valid), 32'd1);
            chk("hold_req_addr", imem_req_addr, 32'h8);
        end
        imem_req_ready = 1'b1;
        wait_pops(6, "release_pops");

        // Redirect with 0x10 and 0x14 in flight (3-cycle memory).
        do_reset(3, 1'b1);
        rst = 1'b0;
        t = 0;
        while (!(pend.size() == 2 && pend[0].addr == 32'h10 && pend[1].addr == 32'h14) && t < 100) begin
            tick();
            t++;
        end
        chk("inflight_found", 32'(t < 100), 32'd1);
        chk("pre_redirect_pops", 32'(seg_pops), 32'd4);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        set_segment(32'h0000_0100);
        #1;
        chk("redirect_blocks_req", 32'(imem_req_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        chk("flush_if_valid", 32'(if_valid), 32'd0);
        chk("flush_if_pc", if_pc, 32'h0);
        chk("redirect_req_addr", imem_req_addr, 32'h100);
        wait_pops(4, "redirect_pops");

        // Redirect coinciding with a live response and a decode pop.
        do_reset(1, 1'b1);
        rst = 1'b0;
        t = 0;
        while (!(if_valid && imem_rsp_valid) && t < 20) begin
            tick();
            t++;
        end
        chk("collide_found", 32'(t < 20), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        set_segment(32'h0000_0200);
        tick();
        redirect_valid = 1'b0;
        chk("collide_if_valid", 32'(if_valid), 32'd0);
        wait_pops(4, "collide_pops");

        // Redirect to the top of the address space: PC wraps to 0.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        set_segment(32'hFFFF_FFFC);
        tick();
        redirect_valid = 1'b0;
        chk("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        wait_pops(4, "wrap_pops");

        // Reset pulse mid-stream.
        rst = 1'b1;
        set_segment(RESET_PC);
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_req_addr", imem_req_addr, RESET_PC);
        chk("midrst_req_valid", 32'(imem_req_valid), 32'd1);
        chk("midrst_if_valid", 32'(if_valid), 32'd0);
        tick();
        chk("midrst_if_valid_next", 32'(if_valid), 32'd0);
        wait_pops(4, "midrst_pops");

        tick();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
